// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM states, owner encoding
// and the all-bytes enable used for fetches.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the memory port: data side has priority, fetch is forced
// through after STARVE_MAX consecutive lost conflicts.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   if_req,
  input  logic   dm_req,
  output owner_t winner
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       conflict;
  logic       if_forced;

  assign conflict  = if_req & dm_req;
  assign if_forced = conflict && (starve_cnt == STARVE_LIM);

  always_comb begin
    winner = OWN_IF;
    if (dm_req && !if_forced) winner = OWN_DM;
  end

  // Counter only moves on a real grant decision; DM winning alone leaves it alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (en && (if_req || dm_req)) begin
      if (winner == OWN_IF) starve_cnt <= 4'd0;
      else if (conflict)    starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage,
// one transaction at a time. Define MEM_ARB_PERF_EN to add performance counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [3:0]      dm_be,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [XLEN-1:0] dm_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]     perf_conflicts,
  output logic [31:0]     perf_if_wait
`endif
);

  arb_state_t      state;
  owner_t          winner;
  owner_t          owner_p0;
  logic            req_we_p0;
  logic [3:0]      req_be_p0;
  logic [XLEN-1:0] req_addr_p0;
  logic [XLEN-1:0] req_wdata_p0;
  logic [XLEN-1:0] if_rdata_p1;
  logic [XLEN-1:0] dm_rdata_p1;
  logic            idle;
  logic            issue;
  logic            grant;

  assign idle  = (state == IDLE);
  assign issue = (state == ISSUE);
  // Grants are gated by reset so every output reads 0 while it is held.
  assign grant = idle && (if_req || dm_req) && reset;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .reset  (reset),
    .en     (idle),
    .if_req (if_req),
    .dm_req (dm_req),
    .winner (winner)
  );

  assign if_gnt = grant && (winner == OWN_IF);
  assign dm_gnt = grant && (winner == OWN_DM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      owner_p0 <= OWN_IF;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state    <= ISSUE;
          owner_p0 <= winner;
        end
        ISSUE:   if (mem_gnt)    state <= WAIT;
        WAIT:    if (mem_rvalid) state <= RESP;
        RESP:                    state <= IDLE;
        default:                 state <= IDLE;
      endcase
    end
  end

  // Request latch (p0): captured at grant so the requester may move on.
  always_ff @(posedge clk) begin
    if (grant) begin
      if (winner == OWN_IF) begin
        req_we_p0    <= 1'b0;
        req_be_p0    <= BE_ALL;
        req_addr_p0  <= if_addr;
        req_wdata_p0 <= '0;
      end else begin
        req_we_p0    <= dm_we;
        req_be_p0    <= dm_be;
        req_addr_p0  <= dm_addr;
        req_wdata_p0 <= dm_wdata;
      end
    end
  end

  // Memory side is driven only in ISSUE, keeping the bus at 0 otherwise.
  assign mem_req   = issue;
  assign mem_we    = issue && req_we_p0;
  assign mem_be    = issue ? req_be_p0    : 4'h0;
  assign mem_addr  = issue ? req_addr_p0  : '0;
  assign mem_wdata = issue ? req_wdata_p0 : '0;

  // Response stage (p1): per-port read data, held until that port's next response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_rdata_p1 <= '0;
      dm_rdata_p1 <= '0;
    end else if ((state == WAIT) && mem_rvalid) begin
      if (owner_p0 == OWN_IF) if_rdata_p1 <= mem_rdata;
      else                    dm_rdata_p1 <= req_we_p0 ? '0 : mem_rdata;
    end
  end

  assign if_rdata  = if_rdata_p1;
  assign dm_rdata  = dm_rdata_p1;
  assign if_rvalid = (state == RESP) && (owner_p0 == OWN_IF);
  assign dm_rvalid = (state == RESP) && (owner_p0 == OWN_DM);
  assign busy      = !idle;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_conflicts <= 32'd0;
      perf_if_wait   <= 32'd0;
    end else begin
      if (idle && if_req && dm_req) perf_conflicts <= perf_conflicts + 32'd1;
      if (if_req && !if_gnt)        perf_if_wait   <= perf_if_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and a response
// scoreboard fed in predicted grant order.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_conflicts;
  logic [31:0] perf_if_wait;
`endif

  mem_port_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_be      (dm_be),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_conflicts (perf_conflicts),
    .perf_if_wait   (perf_if_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected responses (port: 0 = IF, 1 = DM)
  typedef struct {
    bit          port;
    logic [31:0] data;
  } rsp_t;
  rsp_t sb[$];

  // Memory model
  logic [31:0] mem [0:1023];
  int  gnt_delay = 0;
  int  rv_delay  = 1;
  bit  spur      = 1'b0;
  int  gnt_cnt   = 0;
  int  rv_cnt    = 0;
  bit  pend      = 1'b0;
  logic [31:0] pend_data;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h10 >> 2]  = 32'h00A0_0093;
    mem[32'h40 >> 2]  = 32'h0000_0513;
    mem[32'h200 >> 2] = 32'hCAFE_F00D;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hA5A5_A5A5;
    forever begin
      @(posedge clk);
      #2;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hA5A5_A5A5;
      if (!reset) begin
        pend    = 1'b0;
        gnt_cnt = 0;
      end else if (pend) begin
        rv_cnt--;
        if (rv_cnt <= 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pend_data;
          pend       = 1'b0;
        end
      end else if (mem_req) begin
        if (gnt_cnt < gnt_delay) begin
          if (spur && gnt_cnt == 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0_BAD0;
          end
          gnt_cnt++;
        end else begin
          int idx;
          idx     = int'(mem_addr[11:2]);
          mem_gnt = 1'b1;
          gnt_cnt = 0;
          pend    = 1'b1;
          rv_cnt  = rv_delay;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
            pend_data = 32'h1234_5678;
          end else begin
            pend_data = mem[idx];
          end
        end
      end
    end
  end

  // Monitor
  int          if_gnt_n = 0, dm_gnt_n = 0, if_rv_n = 0, dm_rv_n = 0;
  int          if_rv_cyc = -1, dm_rv_cyc = -1, mreq_rise_cyc = -1;
  bit          mreq_prev = 1'b0;
  logic        iss_we;
  logic [3:0]  iss_be;
  logic [31:0] iss_addr, iss_wdata;

  task automatic rsp_check(input bit port, input logic [31:0] data);
    rsp_t e;
    check("rsp_expected", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_port", 32'(port), 32'(e.port));
      check("rsp_data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (if_gnt) if_gnt_n++;
    if (dm_gnt) dm_gnt_n++;
    if (if_gnt || dm_gnt) check("gnt_exclusive", 32'(if_gnt & dm_gnt), 32'd0);
    if (mem_req && !mreq_prev) mreq_rise_cyc = cyc;
    mreq_prev = mem_req;
    if (mem_req && mem_gnt) begin
      iss_we    = mem_we;
      iss_be    = mem_be;
      iss_addr  = mem_addr;
      iss_wdata = mem_wdata;
    end
    if (if_rvalid) begin
      if_rv_n++;
      if_rv_cyc = cyc;
      rsp_check(1'b0, if_rdata);
    end
    if (dm_rvalid) begin
      dm_rv_n++;
      dm_rv_cyc = cyc;
      rsp_check(1'b1, dm_rdata);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: all drive at posedge+1 and return at posedge+1
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit dm, output int gc);
    bit seen = 1'b0;
    gc = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (dm ? dm_gnt : if_gnt) begin
        seen = 1'b1;
        gc   = cyc;
      end
    end
    if (!seen) check(dm ? "dm_gnt_timeout" : "if_gnt_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic if_access(input logic [31:0] a, output int gc);
    if_req  = 1'b1;
    if_addr = a;
    wait_gnt(1'b0, gc);
    if_req  = 1'b0;
    if_addr = 32'hFFFF_FFFC;
  endtask

  task automatic dm_access(input logic we, input logic [3:0] be, input logic [31:0] a,
                           input logic [31:0] wd, output int gc);
    dm_req   = 1'b1;
    dm_we    = we;
    dm_be    = be;
    dm_addr  = a;
    dm_wdata = wd;
    wait_gnt(1'b1, gc);
    dm_req   = 1'b0;
    dm_we    = 1'b1;
    dm_be    = 4'h0;
    dm_addr  = 32'hFFFF_FFFC;
    dm_wdata = 32'h5555_5555;
  endtask

  task automatic wait_idle(output int ic);
    bit done = 1'b0;
    ic = -1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        ic   = cyc;
      end
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t0, gi, gd, ic, rv0, n;
    bit exp_port[6];
    bit got_port[6];

    reset = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;

    // Reset state, with requests asserted while reset is held
    tick();
    if_req = 1'b1; dm_req = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("rst_gnts",  32'({if_gnt, dm_gnt}), 32'd0);
    check("rst_ctrl",  32'({busy, mem_req, mem_we, if_rvalid, dm_rvalid}), 32'd0);
    check("rst_rdata", if_rdata | dm_rdata, 32'd0);
    tick();
    if_req = 1'b0; dm_req = 1'b0; reset = 1'b1;
    tick();

    // Single fetch
    sb.push_back('{1'b0, 32'h00A0_0093});
    rv0 = dm_rv_n;
    t0  = cyc;
    if_access(32'h0000_0010, gi);
    check("fetch_gnt_cyc", 32'(gi - t0), 32'd0);
    wait_idle(ic);
    check("fetch_mreq_cyc", 32'(mreq_rise_cyc - t0), 32'd1);
    check("fetch_we", 32'(iss_we), 32'd0);
    check("fetch_be", 32'(iss_be), 32'hF);
    check("fetch_addr", iss_addr, 32'h10);
    check("fetch_rv_cyc", 32'(if_rv_cyc - t0), 32'd3);
    check("fetch_idle_cyc", 32'(ic - t0), 32'd4);
    check("fetch_dm_silent", 32'(dm_rv_n - rv0), 32'd0);
    tick();

    // Store then load
    sb.push_back('{1'b1, 32'h0});
    dm_access(1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, gd);
    wait_idle(ic);
    check("st_we", 32'(iss_we), 32'd1);
    check("st_be", 32'(iss_be), 32'h3);
    check("st_addr", iss_addr, 32'h100);
    check("st_wdata", iss_wdata, 32'hDEAD_BEEF);
    tick();
    sb.push_back('{1'b1, 32'h0000_BEEF});
    dm_access(1'b0, 4'hF, 32'h100, 32'h0, gd);
    wait_idle(ic);
    check("ld_we", 32'(iss_we), 32'd0);
    check("ld_rdata_hold", dm_rdata, 32'h0000_BEEF);
    check("if_rdata_hold", if_rdata, 32'h00A0_0093);
    tick();

    // Conflict: DM first, IF in the next IDLE cycle
    sb.push_back('{1'b1, 32'hCAFE_F00D});
    sb.push_back('{1'b0, 32'h0000_0513});
    t0 = cyc;
    fork
      if_access(32'h40, gi);
      dm_access(1'b0, 4'hF, 32'h200, 32'h0, gd);
    join
    wait_idle(ic);
    check("conf_dm_gnt_cyc", 32'(gd - t0), 32'd0);
    check("conf_if_gnt_cyc", 32'(gi - t0), 32'd4);
    check("conf_if_rv_cyc", 32'(if_rv_cyc - t0), 32'd7);
    tick();

    // Starvation: DM wins 4 conflicts, IF the 5th, then DM again
    exp_port = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++)
      sb.push_back('{exp_port[i], exp_port[i] ? 32'hCAFE_F00D : 32'h0000_0513});
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h200;
    n = 0;
    for (int i = 0; i < 200 && n < 6; i++) begin
      @(negedge clk);
      if (if_gnt || dm_gnt) begin
        got_port[n] = dm_gnt;
        n++;
      end
    end
    check("starve_gnt_count", 32'(n), 32'd6);
    tick();
    if_req = 1'b0; dm_req = 1'b0;
    for (int i = 0; i < 6; i++) check("starve_order", 32'(got_port[i]), 32'(exp_port[i]));
    wait_idle(ic);
    tick();

    // Memory backpressure with a spurious rvalid during ISSUE
    gnt_delay = 3; rv_delay = 5; spur = 1'b1;
    sb.push_back('{1'b1, 32'h0000_BEEF});
    rv0 = dm_rv_n;
    t0  = cyc;
    dm_access(1'b0, 4'hF, 32'h100, 32'h0, gd);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_mreq", 32'(mem_req), 32'(k <= 4));
      if (k <= 4) check("bp_addr", mem_addr, 32'h100);
    end
    wait_idle(ic);
    check("bp_rv_cyc", 32'(dm_rv_cyc - t0), 32'd10);
    check("bp_rv_once", 32'(dm_rv_n - rv0), 32'd1);
    gnt_delay = 0; rv_delay = 1; spur = 1'b0;
    tick();

    // Reset in WAIT drops the transaction
    rv_delay = 4;
    rv0 = if_rv_n;
    if_access(32'h10, gi);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_in_wait", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    check("mid_ctrl", 32'({if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy, mem_req, mem_we}), 32'd0);
    check("mid_mem_bus", 32'(mem_be) | mem_addr | mem_wdata, 32'd0);
    check("mid_if_rdata", if_rdata, 32'd0);
    check("mid_dm_rdata", dm_rdata, 32'd0);
    tick();
    reset = 1'b1;
    rv_delay = 1;
    repeat (8) tick();
    check("mid_no_rvalid", 32'(if_rv_n - rv0), 32'd0);
    sb.push_back('{1'b0, 32'h00A0_0093});
    if_access(32'h10, gi);
    wait_idle(ic);
    check("mid_fresh_rv", 32'(if_rv_n - rv0), 32'd1);
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
